mips_muldiv: RTL and testbench
==============================

# mips_muldiv

Iterative signed multiply/divide unit that executes the MULT and DIV operations issued by `mips_controller`, which decodes them and selects this unit's results onto HI/LO (`hi_select`/`lo_select` = 2'b11 for MULT, 2'b10 for DIV). It accepts one operation per start pulse and raises `busy` while working so the pipeline can stall any MFHI/MFLO that follows. It produces both 32-bit result halves after a fixed latency. The unit is a responder: the controller initiates, and this block computes and signals completion.

## Interface
Parameters:
- `DATA_WIDTH`, default 32: operand and result-half width. Only 32 is verified.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `start`, input, 1: begin an operation; sampled only in IDLE.
- `op`, input, `muldiv_op_t`: MD_MULT (0) or MD_DIV (1); sampled with `start`.
- `a`, input, 32: rs value; multiplicand or dividend, two's complement.
- `b`, input, 32: rt value; multiplier or divisor, two's complement.
- `busy`, output, 1: high in every state except IDLE.
- `done`, output, 1: one-cycle pulse; results are valid from this cycle on.
- `hi_result`, output, 32: MULT gives product[63:32]; DIV gives the remainder.
- `lo_result`, output, 32: MULT gives product[31:0]; DIV gives the quotient.
- `div_by_zero`, output, 1: valid with `done`; high when a DIV had `b == 0`.

## Operation
- States: IDLE, CALC, FIX, DONE.
  - IDLE → CALC on `start`. On that edge, latch `op`, `|a|`, `|b|`, the sign of `a`, and the result sign.
  - CALC performs exactly 32 iterations, counted by a 5-bit counter from 0 to 31. After iteration 31 it goes to FIX.
  - FIX applies the sign correction and loads `hi_result`/`lo_result`, then goes to DONE.
  - DONE asserts `done` for one cycle, then returns to IDLE unconditionally.
- MULT:
  - Unsigned shift-add on the magnitudes into a 64-bit accumulator, one multiplier bit per CALC cycle.
  - If the signs of `a` and `b` differ, FIX negates the full 64-bit product.
- DIV:
  - Restoring division on the magnitudes, one quotient bit per cycle; a 33-bit partial remainder is required.
  - The quotient is negated when the signs differ.
  - The remainder takes the sign of the dividend `a`.
- Magnitudes are 32-bit unsigned, so `|0x8000_0000|` is 0x8000_0000 with no overflow.
- Divide by zero:
  - Latency is unchanged.
  - `lo_result` = 0xFFFF_FFFF, `hi_result` = `a` as originally given, `div_by_zero` = 1.
  - This is checked against the latched `b`, not detected by the iteration.
- 0x8000_0000 / 0xFFFF_FFFF (−1): `lo_result` = 0x8000_0000, `hi_result` = 0. No exception.
- Holding:
  - `hi_result`, `lo_result` and `div_by_zero` keep their values until the next FIX.
  - The operand inputs are not used after the start edge, so they may change while `busy` is high.

## Timing
- Latency: with `start` sampled at edge 0:
  - `busy` is high from cycle 1 through cycle 34 inclusive.
  - `done` is high in cycle 34 only.
  - The earliest next accepted `start` is sampled at the end of cycle 34 (the DONE→IDLE edge). It is ignored, because the FSM is not in IDLE when that edge samples. The earliest accepted `start` is therefore in cycle 35.
- `start` while `busy` is ignored and does not alter the operation in flight.
- `busy` and `done` are decoded from registered state and carry no combinational path from the inputs.
- Reset values:
  - State = IDLE, counter = 0.
  - `busy` = 0, `done` = 0, `div_by_zero` = 0.
  - `hi_result` = 0, `lo_result` = 0.
- Reset mid-operation aborts immediately: no `done` follows, the results return to 0, and the unit is ready for `start` in the first cycle after `rst` deasserts.

## Structure
- `mips_pkg` adds:
  - `typedef enum logic {MD_MULT, MD_DIV} muldiv_op_t`
  - `MULDIV_ITERS = 32`
  - the state enum `muldiv_state_t`
- Single module with no sub-module. The shared abs/negate logic is a local function.
- The controller-side glue (`start` = opcode RType with funct MULT/DIV, stall on `busy`) lives in the top level, not in this block.

## Test plan
- MULT `a`=7, `b`=0xFFFF_FFFD (−3) → in cycle 34, `done`=1, `hi_result`=0xFFFF_FFFF, `lo_result`=0xFFFF_FFEB; `busy` high in cycles 1–34.
- MULT 0x8000_0000 × 0x8000_0000 → `hi_result`=0x4000_0000, `lo_result`=0.
- DIV −7/2 → `lo_result`=0xFFFF_FFFD, `hi_result`=0xFFFF_FFFF. DIV 7/−2 → `lo_result`=0xFFFF_FFFD, `hi_result`=1. DIV 0x8000_0000/−1 → `lo_result`=0x8000_0000, `hi_result`=0.
- DIV 5/0 → in cycle 34, `div_by_zero`=1, `lo_result`=0xFFFF_FFFF, `hi_result`=5. A following MULT 2×3 → `div_by_zero`=0, `lo_result`=6.
- `start` with new operands in cycles 5 and 34 of a running MULT → ignored, the original result is produced, and exactly one `done` pulse occurs.
- `rst` asserted asynchronously in cycle 10 of a DIV → `busy`, results and `done` go to 0 at once, no `done` pulse follows, and a new `start` after release completes normally.

Source files
------------

// File: rtl/mips_pkg.sv
// ----------------------------------------------------------------------------
// mips_pkg
// Shared types and constants for the MIPS multiply/divide unit.
//   muldiv_op_t     : operation selector, MD_MULT (0) or MD_DIV (1)
//   muldiv_state_t  : FSM state encoding of the multiply/divide unit
//   MULDIV_ITERS    : number of CALC iterations (one result bit per cycle)
// ----------------------------------------------------------------------------
package mips_pkg;

    typedef enum logic {
        MD_MULT = 1'b0,
        MD_DIV  = 1'b1
    } muldiv_op_t;

    localparam int MULDIV_ITERS = 32;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2,
        MD_DONE = 2'd3
    } muldiv_state_t;

endpackage : mips_pkg

// File: rtl/mips_muldiv_if.sv
// ----------------------------------------------------------------------------
// mips_muldiv_if
// Request/response bundle between the controller and the multiply/divide unit.
//   master (controller) drives : start, op, a, b
//   slave  (mips_muldiv) drives: busy, done, hi_result, lo_result, div_by_zero
// ----------------------------------------------------------------------------
interface mips_muldiv_if
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = 32
);

    logic                  start;
    muldiv_op_t            op;
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] hi_result;
    logic [DATA_WIDTH-1:0] lo_result;
    logic                  div_by_zero;

    modport master (
        output start, op, a, b,
        input  busy, done, hi_result, lo_result, div_by_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi_result, lo_result, div_by_zero
    );

endinterface : mips_muldiv_if

// File: rtl/mips_muldiv.sv
// ----------------------------------------------------------------------------
// mips_muldiv
// Iterative signed multiply/divide unit (MULT / DIV). One operation per start
// pulse; fixed latency of 34 cycles from the start edge to the done pulse.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : mips_muldiv_if.slave
//          start/op/a/b           -> request, sampled only in IDLE
//          busy                   -> high in every state except IDLE
//          done                   -> one-cycle completion pulse
//          hi_result/lo_result    -> MULT: product[63:32]/[31:0]
//                                    DIV : remainder/quotient
//          div_by_zero            -> DIV issued with b == 0
// ----------------------------------------------------------------------------
module mips_muldiv
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    mips_muldiv_if.slave  bus
);

    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(MULDIV_ITERS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MULDIV_ITERS - 1);

    // Conditional two's-complement negate; with neg = sign bit it is |v|.
    // The magnitude of the most negative value is the same bit pattern,
    // which is correct when read as unsigned.
    function automatic logic [W-1:0] f_cneg(input logic [W-1:0] v,
                                            input logic         neg);
        return neg ? (~v + {{(W-1){1'b0}}, 1'b1}) : v;
    endfunction

    function automatic logic [2*W-1:0] f_cneg_wide(input logic [2*W-1:0] v,
                                                   input logic           neg);
        return neg ? (~v + {{(2*W-1){1'b0}}, 1'b1}) : v;
    endfunction

    // ---------------------------------------------------------------- state
    muldiv_state_t     r_state;
    muldiv_state_t     w_state_next;
    logic [CNT_W-1:0]  r_cnt;

    // Operation context latched on the start edge
    muldiv_op_t        r_op;
    logic [W-1:0]      r_mag_b;     // |b|: multiplicand-side / divisor
    logic [W-1:0]      r_a_orig;    // a as given, returned on divide by zero
    logic              r_a_neg;     // remainder sign
    logic              r_res_neg;   // product / quotient sign

    // Working registers: {r_part, r_lo} is the 64-bit product during MULT;
    // during DIV r_part is the partial remainder and r_lo shifts the dividend
    // out at the top while quotient bits enter at the bottom.
    logic [W-1:0]      r_part;
    logic [W-1:0]      r_lo;

    // Result registers, held until the next FIX
    logic [W-1:0]      r_hi_result;
    logic [W-1:0]      r_lo_result;
    logic              r_div_by_zero;

    // ---------------------------------------------------------------- step
    logic [W:0]        w_mul_sum;
    logic [W:0]        w_div_shift;
    logic [W-1:0]      w_div_diff;
    logic              w_div_ge;
    logic [2*W-1:0]    w_prod_signed;
    logic [W-1:0]      w_quo_signed;
    logic [W-1:0]      w_rem_signed;
    logic              w_b_zero;
    logic              w_busy;
    logic              w_done;

    always_comb begin
        // Shift-add: add the multiplicand when the current multiplier bit is
        // set; the carry becomes the top bit after the right shift.
        w_mul_sum = {1'b0, r_part} + (r_lo[0] ? {1'b0, r_mag_b} : {(W+1){1'b0}});

        // Restoring divide: the shifted remainder needs W+1 bits because it
        // can reach 2*|b|-1 before the trial subtraction.
        w_div_shift = {r_part, r_lo[W-1]};
        w_div_ge    = (w_div_shift >= {1'b0, r_mag_b});
        // When the subtraction succeeds the difference is below |b|, so the
        // low W bits are exact.
        w_div_diff  = w_div_shift[W-1:0] - r_mag_b;

        w_prod_signed = f_cneg_wide({r_part, r_lo}, r_res_neg);
        w_quo_signed  = f_cneg(r_lo, r_res_neg);
        w_rem_signed  = f_cneg(r_part, r_a_neg);
        w_b_zero      = (r_mag_b == {W{1'b0}});
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= MD_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_busy       = 1'b1;
        w_done       = 1'b0;
        case (r_state)
            MD_IDLE: begin
                w_busy = 1'b0;
                if (bus.start) begin
                    w_state_next = MD_CALC;
                end
            end
            MD_CALC: begin
                if (r_cnt == LAST_CNT) begin
                    w_state_next = MD_FIX;
                end
            end
            MD_FIX: begin
                w_state_next = MD_DONE;
            end
            MD_DONE: begin
                w_done       = 1'b1;
                w_state_next = MD_IDLE;
            end
            default: begin
                w_state_next = MD_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt         <= '0;
            r_op          <= MD_MULT;
            r_mag_b       <= '0;
            r_a_orig      <= '0;
            r_a_neg       <= 1'b0;
            r_res_neg     <= 1'b0;
            r_part        <= '0;
            r_lo          <= '0;
            r_hi_result   <= '0;
            r_lo_result   <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                MD_IDLE: begin
                    if (bus.start) begin
                        r_op      <= bus.op;
                        r_lo      <= f_cneg(bus.a, bus.a[W-1]);
                        r_mag_b   <= f_cneg(bus.b, bus.b[W-1]);
                        r_a_orig  <= bus.a;
                        r_a_neg   <= bus.a[W-1];
                        r_res_neg <= bus.a[W-1] ^ bus.b[W-1];
                        r_part    <= '0;
                        r_cnt     <= '0;
                    end
                end
                MD_CALC: begin
                    r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (r_op == MD_MULT) begin
                        r_part <= w_mul_sum[W:1];
                        r_lo   <= {w_mul_sum[0], r_lo[W-1:1]};
                    end else begin
                        r_part <= w_div_ge ? w_div_diff : w_div_shift[W-1:0];
                        r_lo   <= {r_lo[W-2:0], w_div_ge};
                    end
                end
                MD_FIX: begin
                    if (r_op == MD_MULT) begin
                        r_hi_result   <= w_prod_signed[2*W-1:W];
                        r_lo_result   <= w_prod_signed[W-1:0];
                        r_div_by_zero <= 1'b0;
                    end else if (w_b_zero) begin
                        // Iteration result is discarded; fixed sentinel values.
                        r_hi_result   <= r_a_orig;
                        r_lo_result   <= {W{1'b1}};
                        r_div_by_zero <= 1'b1;
                    end else begin
                        r_hi_result   <= w_rem_signed;
                        r_lo_result   <= w_quo_signed;
                        r_div_by_zero <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ---------------------------------------------------------------- outputs
    assign bus.busy        = w_busy;
    assign bus.done        = w_done;
    assign bus.hi_result   = r_hi_result;
    assign bus.lo_result   = r_lo_result;
    assign bus.div_by_zero = r_div_by_zero;

endmodule : mips_muldiv

// File: tb/tb_mips_muldiv.sv
// ----------------------------------------------------------------------------
// tb_mips_muldiv
// Self-checking bench for mips_muldiv: directed corner cases, start-while-busy,
// asynchronous reset mid-operation, and randomized operands compared against
// a plain signed-arithmetic reference model.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mips_muldiv;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    mips_muldiv_if #(.DATA_WIDTH(32)) mdif ();

    mips_muldiv #(.DATA_WIDTH(32)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (mdif)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: 64-bit signed arithmetic. SV division truncates toward zero
    // and % takes the sign of the dividend, matching MIPS DIV semantics.
    function automatic void model(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
        longint sa, sb, p, q, r;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        dbz = 1'b0;
        if (!is_div) begin
            p  = sa * sb;
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 32'd0) begin
            hi  = a;
            lo  = 32'hFFFF_FFFF;
            dbz = 1'b1;
        end else begin
            q  = sa / sb;
            r  = sa % sb;
            hi = r[31:0];
            lo = q[31:0];
        end
    endfunction

    // Issues one operation and checks busy/done every cycle 1..35 plus the
    // results from cycle 34 onward. With inject set, extra starts carrying
    // other operands are driven in cycles 5 and 34.
    task automatic run_op(input logic is_div, input logic [31:0] a_v, input logic [31:0] b_v,
                          input bit inject);
        logic [31:0] e_hi, e_lo;
        logic        e_dbz;
        int          dones;
        model(is_div, a_v, b_v, e_hi, e_lo, e_dbz);
        @(negedge clk);
        check("idle_busy", {63'd0, mdif.busy}, 64'd0);
        mdif.start = 1'b1;
        mdif.op    = is_div ? MD_DIV : MD_MULT;
        mdif.a     = a_v;
        mdif.b     = b_v;
        @(posedge clk);
        #1;
        mdif.start = 1'b0;
        mdif.a     = $urandom;
        mdif.b     = $urandom;
        mdif.op    = ($urandom_range(0, 1) == 1) ? MD_DIV : MD_MULT;
        dones = 0;
        for (int k = 1; k <= 35; k++) begin
            @(negedge clk);
            if (inject && (k == 5 || k == 34)) begin
                mdif.start = 1'b1;
                mdif.a     = $urandom;
                mdif.b     = $urandom;
                mdif.op    = ($urandom_range(0, 1) == 1) ? MD_DIV : MD_MULT;
            end else begin
                mdif.start = 1'b0;
            end
            if (mdif.done) dones++;
            check($sformatf("busy_c%0d", k), {63'd0, mdif.busy}, {63'd0, (k <= 34)});
            check($sformatf("done_c%0d", k), {63'd0, mdif.done}, {63'd0, (k == 34)});
            if (k >= 34) begin
                check($sformatf("hi_c%0d", k),  {32'd0, mdif.hi_result}, {32'd0, e_hi});
                check($sformatf("lo_c%0d", k),  {32'd0, mdif.lo_result}, {32'd0, e_lo});
                check($sformatf("dbz_c%0d", k), {63'd0, mdif.div_by_zero}, {63'd0, e_dbz});
            end
        end
        check("done_count", 64'(dones), 64'd1);
        $display("%s a=%h b=%h -> hi=%h lo=%h dbz=%b (exp hi=%h lo=%h dbz=%b)",
                 is_div ? "DIV " : "MULT", a_v, b_v, mdif.hi_result, mdif.lo_result,
                 mdif.div_by_zero, e_hi, e_lo, e_dbz);
    endtask

    task automatic check_cleared(input string pfx);
        check({pfx, "_busy"}, {63'd0, mdif.busy}, 64'd0);
        check({pfx, "_done"}, {63'd0, mdif.done}, 64'd0);
        check({pfx, "_hi"},   {32'd0, mdif.hi_result}, 64'd0);
        check({pfx, "_lo"},   {32'd0, mdif.lo_result}, 64'd0);
        check({pfx, "_dbz"},  {63'd0, mdif.div_by_zero}, 64'd0);
    endtask

    task automatic reset_mid_div();
        int dones;
        @(negedge clk);
        mdif.start = 1'b1;
        mdif.op    = MD_DIV;
        mdif.a     = 32'h1234_5678;
        mdif.b     = 32'h0000_0123;
        @(posedge clk);
        #1;
        mdif.start = 1'b0;
        for (int k = 1; k <= 10; k++) @(negedge clk);
        check("pre_rst_busy", {63'd0, mdif.busy}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check_cleared("arst");
        @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (mdif.done) dones++;
        end
        check("post_rst_busy", {63'd0, mdif.busy}, 64'd0);
        check("post_rst_dones", 64'(dones), 64'd0);
        $display("RST  mid-DIV abort, done pulses afterwards=%0d", dones);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'(signed'(int'($urandom_range(0, 20)) - 10));
            1:       return 32'h8000_0000;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'd0;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst        = 1'b1;
        mdif.start = 1'b0;
        mdif.op    = MD_MULT;
        mdif.a     = '0;
        mdif.b     = '0;
        repeat (3) @(negedge clk);
        check_cleared("reset");
        #2;
        rst = 1'b0;

        run_op(1'b0, 32'd7,          32'hFFFF_FFFD, 1'b0);
        run_op(1'b0, 32'h8000_0000,  32'h8000_0000, 1'b0);
        run_op(1'b1, 32'hFFFF_FFF9,  32'd2,         1'b0);
        run_op(1'b1, 32'd7,          32'hFFFF_FFFE, 1'b0);
        run_op(1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 1'b0);
        run_op(1'b1, 32'd5,          32'd0,         1'b0);
        run_op(1'b0, 32'd2,          32'd3,         1'b0);
        run_op(1'b1, 32'hFFFF_FFF0,  32'd0,         1'b0);
        run_op(1'b0, 32'h1357_9BDF,  32'hFEDC_BA98, 1'b1);

        reset_mid_div();
        run_op(1'b1, 32'd100, 32'd7, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_op(1'($urandom_range(0, 1)), pick_operand(), pick_operand(),
                   ($urandom_range(0, 7) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_mips_muldiv
